// File: rtl/brd_ctrl_pkg.sv
// Shared definitions for the board control register bank: access modes and
// the location of the STATUS/EVENT registers after the control registers.
package brd_ctrl_pkg;

  localparam logic [1:0] MODE_WR  = 2'b00;
  localparam logic [1:0] MODE_SET = 2'b01;
  localparam logic [1:0] MODE_CLR = 2'b10;
  localparam logic [1:0] MODE_TGL = 2'b11;

  function automatic int status_index(input int nregs);
    return nregs;
  endfunction

  function automatic int event_index(input int nregs);
    return nregs + 1;
  endfunction

endpackage

// File: rtl/brd_sync_edge.sv
// Two-flop synchroniser for board status, with a delayed copy used to
// detect rising edges of the synchronised value.
module brd_sync_edge #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] hist_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      hist_reg  <= '0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  assign sync = sync2_reg;
  assign rise = sync2_reg & ~hist_reg;

endmodule

// File: rtl/brd_ctrl_bank.sv
// Multi-register board control bank: NREGS control registers with
// write/set/clear/toggle access, self-clearing pulse bits, status and events.
module brd_ctrl_bank
  import brd_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               NREGS      = 4,
  parameter int               IW         = $clog2(NREGS + 2),
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PULSE_MASK = '0,
  parameter int               PULSE_LEN  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cs,
  input  logic                   wen,
  input  logic [IW+1:0]          addr,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [NREGS*WIDTH-1:0] ctrl_out,
  input  logic [WIDTH-1:0]       stat_in,
  output logic                   irq
);

  localparam logic [IW-1:0] STAT_IDX = IW'(status_index(NREGS));
  localparam logic [IW-1:0] EVT_IDX  = IW'(event_index(NREGS));

  logic [1:0]       mode;
  logic [IW-1:0]    idx;
  logic             wr;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] event_reg;

  assign {mode, idx} = addr;
  assign wr = cs & wen;

  function automatic logic [WIDTH-1:0] apply_mode(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] wd);
    case (m)
      MODE_SET: return cur | wd;
      MODE_CLR: return cur & ~wd;
      MODE_TGL: return cur ^ wd;
      default:  return wd;
    endcase
  endfunction

  brd_sync_edge #(.WIDTH(WIDTH)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (stat_in),
    .sync    (status),
    .rise    (rise)
  );

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic             hit;
    logic [WIDTH-1:0] alu_val;
    logic [WIDTH-1:0] val_reg;

    assign hit     = wr && (idx == IW'(gi));
    assign alu_val = apply_mode(mode, val_reg, din);
    assign ctrl_out[gi*WIDTH +: WIDTH] = val_reg;

    if (gi == 0) begin : g_pulse
      logic [7:0]       pulse_cnt_reg;
      logic [7:0]       pulse_cnt_next;
      logic [WIDTH-1:0] val_next;

      // A write leaving any pulse bit high restarts the full pulse; otherwise
      // the counter runs down and clears the pulse bits on its 1 -> 0 step.
      always_comb begin
        val_next       = val_reg;
        pulse_cnt_next = pulse_cnt_reg;
        if (hit && |(alu_val & PULSE_MASK)) begin
          val_next       = alu_val;
          pulse_cnt_next = 8'(PULSE_LEN);
        end else begin
          if (hit) val_next = alu_val;
          if (pulse_cnt_reg == 8'd1) val_next = val_next & ~PULSE_MASK;
          if (pulse_cnt_reg != 8'd0) pulse_cnt_next = pulse_cnt_reg - 8'd1;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          val_reg       <= RESET_VAL & ~PULSE_MASK;
          pulse_cnt_reg <= '0;
        end else begin
          val_reg       <= val_next;
          pulse_cnt_reg <= pulse_cnt_next;
        end
      end
    end else begin : g_plain
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) val_reg <= RESET_VAL;
        else if (hit) val_reg <= alu_val;
      end
    end
  end

  // New rising edges are OR-ed in after the write-1-to-clear, so set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) event_reg <= '0;
    else event_reg <= (event_reg & ~((wr && idx == EVT_IDX) ? din : '0)) | rise;
  end

  always_comb begin
    dout = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (idx == IW'(k)) dout = ctrl_out[k*WIDTH +: WIDTH];
    end
    if (idx == STAT_IDX) dout = status;
    if (idx == EVT_IDX)  dout = event_reg;
  end

  assign irq = |(event_reg & ctrl_out[(NREGS-1)*WIDTH +: WIDTH]);

endmodule

// File: tb/tb_brd_ctrl_bank.sv
// Scoreboard bench for brd_ctrl_bank: the driver queues hand-computed expected
// readback, a negedge monitor pops and compares whenever a read is presented.
module tb_brd_ctrl_bank;

  localparam int WIDTH = 32;
  localparam int NREGS = 4;
  localparam int IW    = 3;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   cs = 1'b0;
  logic                   wen = 1'b0;
  logic [IW+1:0]          addr = '0;
  logic [WIDTH-1:0]       din = '0;
  logic [WIDTH-1:0]       dout;
  logic [NREGS*WIDTH-1:0] ctrl_out;
  logic [WIDTH-1:0]       stat_in = '0;
  logic                   irq;

  typedef struct {
    string       name;
    logic [31:0] exp_dout;
    logic        exp_irq;
    int          word;
    logic [31:0] exp_word;
  } exp_t;

  exp_t exp_q[$];
  logic chk_valid = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  brd_ctrl_bank #(
    .WIDTH(WIDTH), .NREGS(NREGS), .IW(IW),
    .RESET_VAL(32'h0000_00F0), .PULSE_MASK(32'h1), .PULSE_LEN(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .wen(wen), .addr(addr), .din(din),
    .dout(dout), .ctrl_out(ctrl_out), .stat_in(stat_in), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: read presented with empty queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (dout !== e.exp_dout) begin
          n_bad++;
          $display("FAIL %s dout: got %h required %h", e.name, dout, e.exp_dout);
        end else $display("ok   %s dout=%h", e.name, dout);
        n_cmp++;
        if (irq !== e.exp_irq) begin
          n_bad++;
          $display("FAIL %s irq: got %b required %b", e.name, irq, e.exp_irq);
        end
        if (e.word >= 0) begin
          n_cmp++;
          if (ctrl_out[e.word*WIDTH +: WIDTH] !== e.exp_word) begin
            n_bad++;
            $display("FAIL %s ctrl_out[%0d]: got %h required %h", e.name, e.word,
                     ctrl_out[e.word*WIDTH +: WIDTH], e.exp_word);
          end
        end
      end
    end
  end

  task automatic do_write(input logic [1:0] m, input int i, input logic [31:0] d);
    cs = 1'b1; wen = 1'b1; addr = {m, 3'(i)}; din = d;
    @(posedge clk); #1;
    cs = 1'b0; wen = 1'b0;
  endtask

  task automatic do_read(input string name, input int i, input logic [31:0] e,
                         input logic ei, input int w = -1, input logic [31:0] ew = '0);
    exp_t x;
    x.name = name; x.exp_dout = e; x.exp_irq = ei; x.word = w; x.exp_word = ew;
    addr = {2'b11, 3'(i)};
    exp_q.push_back(x);
    chk_valid = 1'b1;
    @(posedge clk); #1;
    chk_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    do_read("rst_ctrl0", 0, 32'hF0, 1'b0, 0, 32'hF0);
    do_read("rst_ctrl1", 1, 32'hF0, 1'b0, 1, 32'hF0);
    do_read("rst_ctrl3", 3, 32'hF0, 1'b0, 3, 32'hF0);
    do_read("rst_status", 4, 32'h0, 1'b0);
    do_read("rst_event", 5, 32'h0, 1'b0);

    do_write(2'b00, 1, 32'h0F0F); do_read("wr", 1, 32'h0F0F, 1'b0, 1, 32'h0F0F);
    do_write(2'b01, 1, 32'hF000); do_read("set", 1, 32'hFF0F, 1'b0, 1, 32'hFF0F);
    do_write(2'b10, 1, 32'h000F); do_read("clr", 1, 32'hFF00, 1'b0, 1, 32'hFF00);
    do_write(2'b11, 1, 32'h00FF); do_read("tgl", 1, 32'hFFFF, 1'b0, 1, 32'hFFFF);

    // Single pulse: bit0 high for exactly four cycles, bit1 stays.
    do_write(2'b00, 0, 32'h3);
    for (int i = 0; i < 6; i++)
      do_read($sformatf("pulse_c%0d", i), 0, (i < 4) ? 32'h3 : 32'h2, 1'b0);

    // Rewrite two cycles into the pulse: six cycles high in total.
    do_write(2'b00, 0, 32'h3);
    do_read("repulse_pre", 0, 32'h3, 1'b0);
    do_write(2'b00, 0, 32'h3);
    for (int i = 0; i < 6; i++)
      do_read($sformatf("repulse_c%0d", i), 0, (i < 4) ? 32'h3 : 32'h2, 1'b0);

    do_write(2'b00, 3, 32'h20);
    stat_in = 32'h20;
    do_read("stat_e0", 4, 32'h0, 1'b0);
    do_read("stat_e1", 4, 32'h0, 1'b0);
    do_read("evt_e2", 5, 32'h0, 1'b0);
    do_read("evt_e3", 5, 32'h20, 1'b1);
    do_read("stat_e4", 4, 32'h20, 1'b1);
    do_write(2'b01, 5, 32'h20);
    do_read("evt_w1c", 5, 32'h0, 1'b0);

    stat_in = 32'h0;
    do_read("fall_g0", 4, 32'h20, 1'b0);
    do_read("fall_g1", 4, 32'h20, 1'b0);
    do_read("fall_g2", 4, 32'h0, 1'b0);
    do_read("fall_evt", 5, 32'h0, 1'b0);
    stat_in = 32'h20;
    do_read("rise_f0", 5, 32'h0, 1'b0);
    do_read("rise_f1", 5, 32'h0, 1'b0);
    do_write(2'b10, 5, 32'h20);
    do_read("set_wins", 5, 32'h20, 1'b1);

    do_read("oob_read", 6, 32'h0, 1'b1);
    do_write(2'b00, 6, 32'hFFFF_FFFF);
    do_write(2'b01, 4, 32'hFFFF_FFFF);
    do_read("oob_ctrl0", 0, 32'h2, 1'b1, 0, 32'h2);
    do_read("oob_ctrl1", 1, 32'hFFFF, 1'b1, 2, 32'hF0);
    do_read("oob_ctrl3", 3, 32'h20, 1'b1, 3, 32'h20);
    do_read("oob_event", 5, 32'h20, 1'b1);

    cs = 1'b0; wen = 1'b1; addr = {2'b00, 3'd1}; din = 32'h1234;
    @(posedge clk); #1 wen = 1'b0;
    do_read("cs_low", 1, 32'hFFFF, 1'b1, 1, 32'hFFFF);

    stat_in = 32'h0;
    do_write(2'b00, 0, 32'h1);
    #2 reset_n = 1'b0;
    do_read("async_rst_ctrl1", 1, 32'hF0, 1'b0, 1, 32'hF0);
    do_read("async_rst_event", 5, 32'h0, 1'b0, 3, 32'hF0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++)
      do_read($sformatf("post_rst_ctrl0_%0d", i), 0, 32'hF0, 1'b0, 0, 32'hF0);

    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
